// File: rtl/cdb_broadcaster.sv
// ---------------------------------------------------------------------------
// cdb_broadcaster
//  Transmitter side of the common data bus. Completed results (label, data)
//  from NUM_SRC functional units are queued in per-source FIFOs. A round-robin
//  arbiter picks one FIFO head per cycle and drives it onto the registered
//  broadcast outputs (BCEN/BClabel/BCdata). Label 0 means "no tag": such
//  results are consumed at the handshake but never stored or broadcast.
//
// Ports
//  clk        in   clock, rising edge
//  nRST       in   asynchronous reset, active-low
//  flush      in   synchronous flush of every buffered result
//  src_valid  in   [NUM_SRC]     result offered by source i
//  src_ready  out  [NUM_SRC]     source i FIFO can accept this cycle
//  src_label  in   [NUM_SRC*LW]  label of source i at [i*LW +: LW]
//  src_data   in   [NUM_SRC*DW]  data of source i at [i*DW +: DW]
//  BCEN       out  broadcast valid (registered)
//  BClabel    out  broadcast label (registered, 0 when BCEN is low)
//  BCdata     out  broadcast data  (registered, 0 when BCEN is low)
//  busy       out  any FIFO non-empty or a broadcast on the bus
// ---------------------------------------------------------------------------
module cdb_broadcaster #(
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 2,
   parameter int DW      = 32,
   parameter int LW      = 4
) (
   input  logic                  clk,
   input  logic                  nRST,
   input  logic                  flush,
   input  logic [NUM_SRC-1:0]    src_valid,
   output logic [NUM_SRC-1:0]    src_ready,
   input  logic [NUM_SRC*LW-1:0] src_label,
   input  logic [NUM_SRC*DW-1:0] src_data,
   output logic                  BCEN,
   output logic [LW-1:0]         BClabel,
   output logic [DW-1:0]         BCdata,
   output logic                  busy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(NUM_SRC);

   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [SW:0]   NSRC_C = (SW+1)'(NUM_SRC);
   localparam logic [SW-1:0] LAST_C = SW'(NUM_SRC - 1);

   logic [LW-1:0] lbl_mem_q [NUM_SRC][DEPTH];
   logic [DW-1:0] dat_mem_q [NUM_SRC][DEPTH];

   logic [PW-1:0] rd_ptr_q [NUM_SRC];
   logic [PW-1:0] rd_ptr_d [NUM_SRC];
   logic [PW-1:0] wr_ptr_q [NUM_SRC];
   logic [PW-1:0] wr_ptr_d [NUM_SRC];
   logic [CW-1:0] count_q  [NUM_SRC];
   logic [CW-1:0] count_d  [NUM_SRC];

   logic [NUM_SRC-1:0] push;
   logic [NUM_SRC-1:0] pop;
   logic [NUM_SRC-1:0] nonempty;
   logic [NUM_SRC-1:0] ready;

   logic [SW-1:0] rr_ptr_q;
   logic [SW-1:0] rr_ptr_d;
   logic          grant_valid;
   logic [SW-1:0] grant_idx;
   logic [SW:0]   cand_sum;
   logic [SW-1:0] cand;

   logic [LW-1:0] head_lbl;
   logic [DW-1:0] head_dat;

   logic          bcen_q;
   logic          bcen_d;
   logic [LW-1:0] bclabel_q;
   logic [LW-1:0] bclabel_d;
   logic [DW-1:0] bcdata_q;
   logic [DW-1:0] bcdata_d;

   // Ready looks only at the registered count, so a pop in the same cycle
   // does not free a slot until the next cycle.
   always_comb begin
      nonempty = '0;
      ready    = '0;
      push     = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         nonempty[i] = (count_q[i] != '0);
         ready[i]    = (count_q[i] != FULL_C) && !flush;
         push[i]     = src_valid[i] && ready[i] && (src_label[i*LW +: LW] != '0);
      end
   end

   assign src_ready = ready;

   // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_SRC.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand_sum    = '0;
      cand        = '0;
      for (int off = 0; off < NUM_SRC; off++) begin
         cand_sum = {1'b0, rr_ptr_q} + (SW+1)'(off);
         if (cand_sum >= NSRC_C) begin
            cand_sum = cand_sum - NSRC_C;
         end
         cand = cand_sum[SW-1:0];
         if (!grant_valid && nonempty[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         pop[i] = grant_valid && !flush && (grant_idx == SW'(i));
      end
   end

   assign head_lbl = lbl_mem_q[grant_idx][rd_ptr_q[grant_idx]];
   assign head_dat = dat_mem_q[grant_idx][rd_ptr_q[grant_idx]];

   // Flush keeps the round-robin position so fairness carries across it.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_valid && !flush) begin
         rr_ptr_d = (grant_idx == LAST_C) ? '0 : grant_idx + 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         rd_ptr_d[i] = rd_ptr_q[i];
         wr_ptr_d[i] = wr_ptr_q[i];
         count_d[i]  = count_q[i];
         if (flush) begin
            rd_ptr_d[i] = '0;
            wr_ptr_d[i] = '0;
            count_d[i]  = '0;
         end else begin
            if (pop[i]) begin
               rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
            end
            if (push[i]) begin
               wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
            end
            case ({push[i], pop[i]})
               2'b10:   count_d[i] = count_q[i] + 1'b1;
               2'b01:   count_d[i] = count_q[i] - 1'b1;
               default: count_d[i] = count_q[i];
            endcase
         end
      end
   end

   // Bus label/data are forced to zero whenever nothing is broadcast.
   always_comb begin
      bcen_d    = grant_valid && !flush;
      bclabel_d = '0;
      bcdata_d  = '0;
      if (bcen_d) begin
         bclabel_d = head_lbl;
         bcdata_d  = head_dat;
      end
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            rd_ptr_q[i] <= '0;
            wr_ptr_q[i] <= '0;
            count_q[i]  <= '0;
         end
         rr_ptr_q  <= '0;
         bcen_q    <= 1'b0;
         bclabel_q <= '0;
         bcdata_q  <= '0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            rd_ptr_q[i] <= rd_ptr_d[i];
            wr_ptr_q[i] <= wr_ptr_d[i];
            count_q[i]  <= count_d[i];
         end
         rr_ptr_q  <= rr_ptr_d;
         bcen_q    <= bcen_d;
         bclabel_q <= bclabel_d;
         bcdata_q  <= bcdata_d;
      end
   end

   // Storage needs no reset: entries are only read while the count says valid.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (push[i]) begin
            lbl_mem_q[i][wr_ptr_q[i]] <= src_label[i*LW +: LW];
            dat_mem_q[i][wr_ptr_q[i]] <= src_data[i*DW +: DW];
         end
      end
   end

   assign BCEN    = bcen_q;
   assign BClabel = bclabel_q;
   assign BCdata  = bcdata_q;
   assign busy    = (|nonempty) || bcen_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
module tb_cdb_broadcaster;

   localparam int N  = 2;
   localparam int D  = 2;
   localparam int DW = 32;
   localparam int LW = 4;

   logic            clk = 1'b0;
   logic            nRST;
   logic            flush;
   logic [N-1:0]    src_valid;
   logic [N-1:0]    src_ready;
   logic [N*LW-1:0] src_label;
   logic [N*DW-1:0] src_data;
   logic            BCEN;
   logic [LW-1:0]   BClabel;
   logic [DW-1:0]   BCdata;
   logic            busy;

   cdb_broadcaster #(.NUM_SRC(N), .DEPTH(D), .DW(DW), .LW(LW)) dut (
      .clk       (clk),
      .nRST      (nRST),
      .flush     (flush),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .src_label (src_label),
      .src_data  (src_data),
      .BCEN      (BCEN),
      .BClabel   (BClabel),
      .BCdata    (BCdata),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [LW-1:0] l;
      logic [DW-1:0] d;
   } item_t;

   item_t         offq0[$];
   item_t         offq1[$];
   item_t         mq0[$];
   item_t         mq1[$];
   item_t         exp_q[$];
   logic [LW-1:0] bc_log[$];
   int            m_rr;
   int            total = 0;
   int            bad = 0;
   bit            drv_en = 1'b0;
   bit            gap_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
      end
   endtask

   function automatic int msize(input int s);
      return (s == 0) ? mq0.size() : mq1.size();
   endfunction

   // Driver: presents each source's offer-queue head, with optional gaps.
   always @(posedge clk) begin
      #2;
      if (drv_en) begin
         src_valid[0]     = (offq0.size() != 0) && !(gap_en && $urandom_range(3) == 0);
         src_label[3:0]   = (offq0.size() != 0) ? offq0[0].l : '0;
         src_data[31:0]   = (offq0.size() != 0) ? offq0[0].d : '0;
         src_valid[1]     = (offq1.size() != 0) && !(gap_en && $urandom_range(3) == 0);
         src_label[7:4]   = (offq1.size() != 0) ? offq1[0].l : '0;
         src_data[63:32]  = (offq1.size() != 0) ? offq1[0].d : '0;
      end
   end

   // Inputs and ready are stable from here to the next edge, so a handshake
   // seen now is the one that completes at that edge.
   always @(negedge clk) begin
      if (nRST && drv_en) begin
         if (src_valid[0] && src_ready[0]) void'(offq0.pop_front());
         if (src_valid[1] && src_ready[1]) void'(offq1.pop_front());
      end
   end

   // Reference model: queues per source, round-robin pick of the oldest head.
   always @(posedge clk or negedge nRST) begin : model
      bit    r0, r1, found;
      item_t it;
      if (!nRST) begin
         mq0.delete();
         mq1.delete();
         exp_q.delete();
         m_rr = 0;
      end else begin
         r0 = (mq0.size() < D) && !flush;
         r1 = (mq1.size() < D) && !flush;
         if (flush) begin
            mq0.delete();
            mq1.delete();
         end else begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
               int s;
               s = (m_rr + k) % N;
               if (!found && msize(s) > 0) begin
                  found = 1'b1;
                  it = (s == 0) ? mq0.pop_front() : mq1.pop_front();
                  exp_q.push_back(it);
                  m_rr = (s + 1) % N;
               end
            end
         end
         if (src_valid[0] && r0 && src_label[3:0] != 0) mq0.push_back({src_label[3:0], src_data[31:0]});
         if (src_valid[1] && r1 && src_label[7:4] != 0) mq1.push_back({src_label[7:4], src_data[63:32]});
      end
   end

   // Monitor: checks every cycle against the model's expected bus content.
   always @(negedge clk) begin : monitor
      bit    exp_bc, exp_busy;
      item_t e;
      exp_bc   = (exp_q.size() != 0);
      exp_busy = exp_bc || (mq0.size() != 0) || (mq1.size() != 0);
      chk("src_ready", 64'(src_ready), 64'({(mq1.size() < D) && !flush, (mq0.size() < D) && !flush}));
      chk("BCEN", 64'(BCEN), 64'(exp_bc));
      chk("busy", 64'(busy), 64'(exp_busy));
      if (exp_bc) begin
         e = exp_q.pop_front();
         chk("BClabel", 64'(BClabel), 64'(e.l));
         chk("BCdata", 64'(BCdata), 64'(e.d));
      end else begin
         chk("idle_bus", {28'd0, BClabel, BCdata}, 64'd0);
      end
      if (BCEN) bc_log.push_back(BClabel);
   end

   task automatic offer(input int s, input logic [LW-1:0] l, input logic [DW-1:0] d);
      if (s == 0) offq0.push_back({l, d});
      else        offq1.push_back({l, d});
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((offq0.size() != 0 || offq1.size() != 0 || mq0.size() != 0 ||
              mq1.size() != 0 || exp_q.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         total++;
         bad++;
         $display("FAIL wait_idle timeout after %0d cycles", budget);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_seq(input string nm, input int n, input logic [31:0] seq);
      chk({nm, "_len"}, 64'(bc_log.size()), 64'(n));
      for (int i = 0; i < n; i++) begin
         if (i < bc_log.size()) chk(nm, 64'(bc_log[i]), 64'(seq[4*i +: 4]));
      end
   endtask

   initial begin
      nRST      = 1'b0;
      flush     = 1'b0;
      src_valid = '0;
      src_label = '0;
      src_data  = '0;

      // Reset with sources offering
      src_valid = 2'b11;
      src_label = 8'h21;
      src_data  = 64'h1234_5678_9abc_def0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_BCEN", 64'(BCEN), 64'd0);
      chk("rst_BClabel", 64'(BClabel), 64'd0);
      chk("rst_BCdata", 64'(BCdata), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      src_valid = '0;
      src_label = '0;
      src_data  = '0;
      @(negedge clk);
      nRST = 1'b1;
      #1;
      chk("rst_ready", 64'(src_ready), 64'h3);
      drv_en = 1'b1;

      // Single result latency
      @(posedge clk); #1;
      bc_log.delete();
      offer(0, 4'd3, 32'hDEADBEEF);
      @(negedge clk); chk("lat_preE0", 64'(BCEN), 64'd0);
      @(negedge clk); chk("lat_afterE0", 64'(BCEN), 64'd0);
      @(negedge clk);
      chk("lat_afterE1", 64'(BCEN), 64'd1);
      chk("lat_label", 64'(BClabel), 64'd3);
      chk("lat_data", 64'(BCdata), 64'hDEADBEEF);
      @(negedge clk);
      chk("lat_pulse_end", 64'(BCEN), 64'd0);
      chk("lat_label_end", 64'(BClabel), 64'd0);
      wait_idle(50);

      // Move the round-robin pointer back to source 0
      @(posedge clk); #1;
      offer(1, 4'd10, 32'hA);
      wait_idle(50);

      // Contention
      @(posedge clk); #1;
      bc_log.delete();
      offer(0, 4'd1, 32'h11);
      offer(1, 4'd2, 32'h22);
      wait_idle(50);
      chk_seq("contention", 2, 32'h21);

      // Full / backpressure
      @(posedge clk); #1;
      bc_log.delete();
      for (int i = 0; i < 4; i++) begin
         offer(0, 4'(1 + i), 32'h100 + 32'(i));
         offer(1, 4'(5 + i), 32'h200 + 32'(i));
      end
      wait_idle(100);
      chk_seq("backpressure", 8, 32'h84736251);

      // Label-zero drop
      @(posedge clk); #1;
      bc_log.delete();
      offer(0, 4'd0, 32'h55);
      wait_idle(50);
      chk("lz_consumed", 64'(offq0.size()), 64'd0);
      chk("lz_no_bc", 64'(bc_log.size()), 64'd0);
      chk("lz_busy", 64'(busy), 64'd0);

      // Flush with three entries pending
      @(posedge clk); #1;
      bc_log.delete();
      offer(0, 4'd1, 32'hF1);
      offer(0, 4'd2, 32'hF2);
      offer(1, 4'd3, 32'hF3);
      offer(1, 4'd4, 32'hF4);
      @(posedge clk); #1;
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_BCEN", 64'(BCEN), 64'd0);
      chk("flush_busy", 64'(busy), 64'd0);
      chk("flush_ready", 64'(src_ready), 64'h3);
      @(posedge clk); #1;
      offer(1, 4'd9, 32'h99);
      wait_idle(50);
      chk_seq("flush_seq", 2, 32'h91);

      // Reset in the middle of a broadcast
      @(posedge clk); #1;
      offer(0, 4'd5, 32'h5);
      offer(1, 4'd6, 32'h6);
      begin
         int n;
         n = 0;
         while (!BCEN && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("mid_rst_seen", 64'(BCEN), 64'd1);
      end
      #1;
      nRST = 1'b0;
      #1;
      chk("mid_rst_BCEN", 64'(BCEN), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      offq0.delete();
      offq1.delete();
      @(negedge clk);
      nRST = 1'b1;
      repeat (2) @(negedge clk);

      // Randomized traffic with gaps, zero labels and occasional flushes
      gap_en = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #1;
         if (offq0.size() < 3 && $urandom_range(2) == 0)
            offer(0, 4'($urandom_range(15)), $urandom);
         if (offq1.size() < 3 && $urandom_range(2) == 0)
            offer(1, 4'($urandom_range(15)), $urandom);
         flush = ($urandom_range(60) == 0);
      end
      @(posedge clk); #1;
      flush = 1'b0;
      wait_idle(200);
      chk("end_busy", 64'(busy), 64'd0);
      chk("end_BCEN", 64'(BCEN), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
